pix_buff_sync_fifo: RTL
=======================

Name: pix_buff_sync_fifo

Overview:
Single-clock, parametrised successor to the dual-clock pixel buffer FIFO. It is used where the producer and consumer of a pixel stream share one clock domain, so no Gray-code pointer crossing is needed. It adds four things the previous block lacks: a first-word-fall-through (FWFT) mode, a synchronous flush, sticky overflow/underflow flags, and an exact occupancy count. Storage is an inferred simple-dual-port RAM.

Parameters:
c_DEPTH_WIDTH, 10, log2 of capacity; capacity = 2^c_DEPTH_WIDTH words; legal range 4..16
c_DATA_WIDTH, 32, word width; legal range 1..1152
c_FWFT, 0, 0 = standard mode (data valid 1 cycle after rd_en); 1 = first-word-fall-through
c_ALMOST_FULL_NUM, 1020, almost_full asserts when water_level >= this value
c_ALMOST_EMPTY_NUM, 4, almost_empty asserts when water_level <= this value

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of contents and flags
wr_en  in  1  write request
wr_data  in  c_DATA_WIDTH  write word
wr_full  out  1  FIFO full
almost_full  out  1  water_level >= c_ALMOST_FULL_NUM
rd_en  in  1  read request (pop in FWFT mode)
rd_data  out  c_DATA_WIDTH  read word
rd_empty  out  1  no readable word
almost_empty  out  1  water_level <= c_ALMOST_EMPTY_NUM
water_level  out  c_DEPTH_WIDTH+1  words accepted and not yet popped
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset and interface:
  - One clock (clk); reset (rst) is asynchronous and active-high.
  - rst asserted: pointers = 0, water_level = 0, rd_empty = 1, wr_full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0, FWFT prefetch stage invalid.
  - RAM contents are not cleared.
- Accepted transactions:
  - wr_acc = wr_en & ~wr_full.
  - rd_acc = rd_en & ~rd_empty.
- Full and empty boundaries:
  - A write while full is dropped, even if rd_acc occurs in the same cycle. overflow sets and stays set.
  - A read while empty is ignored and rd_data holds. underflow sets and stays set.
- Water level:
  - water_level += wr_acc − rd_acc at each edge; simultaneous accept leaves it unchanged.
  - Width is c_DEPTH_WIDTH+1, so water_level reaches 2^c_DEPTH_WIDTH exactly.
- Flags:
  - wr_full = (water_level == 2^c_DEPTH_WIDTH).
  - almost_full and almost_empty are registered compares against the next-state water_level, so they are valid in the same cycle as water_level.
- Pointers: c_DEPTH_WIDTH bits wide and wrap naturally from 2^N−1 to 0.
- Standard mode (c_FWFT=0):
  - rd_empty = (water_level == 0).
  - rd_acc at edge k: the word is on rd_data after edge k+1 (1-cycle latency) and held until the next rd_acc.
  - Write at edge k into an empty FIFO: rd_empty low after edge k.
- FWFT mode (c_FWFT=1):
  - A prefetch stage holds the head word; rd_empty = ~stage_valid.
  - The head word is present on rd_data whenever rd_empty = 0; rd_acc pops it.
  - The next word appears after the same edge if the RAM holds one, otherwise stage_valid clears.
  - Write at edge k into an empty FIFO: rd_empty low after edge k+1. water_level is already 1 after edge k.
  - The prefetch stage counts toward water_level and capacity; capacity is identical in both modes.
- Flush:
  - Same effect as rst, but synchronous.
  - Overrides wr_en and rd_en in the same cycle; nothing is accepted.
- Back-to-back operation: sustained simultaneous wr_acc and rd_acc runs at 1 word/clock in both modes with no bubbles.
- Parameter checks (simulation-time error):
  - c_ALMOST_FULL_NUM > 2^c_DEPTH_WIDTH.
  - c_ALMOST_EMPTY_NUM >= c_ALMOST_FULL_NUM.

Optional Feature:
PIX_BUFF_FIFO_STATS_EN
- Defined:
  - Adds outputs ovf_cnt and udf_cnt, 16 bits each, saturating at 0xFFFF.
  - They count dropped writes and ignored reads.
  - Cleared by rst and flush.
  - Adds output max_level, c_DEPTH_WIDTH+1 bits: the peak water_level since the last rst or flush.
- Undefined: these ports and their registers do not exist; the sticky flags are unchanged.

Decomposition:
- Package pix_buff_pkg holds:
  - FIFO mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
  - Counter width constant STAT_CNT_W = 16.
  - A function returning capacity from a depth width.
- One sub-module, pix_buff_sdp_ram:
  - Inferred simple-dual-port RAM, 1-cycle registered read.
  - Ports: wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data.
- Control, level and flags stay in the top module.

Test Plan:
- Std mode, DW=4, W=8: write 0x01..0x10 (16 words) → wr_full=1 and water_level=16 after the 16th edge. A 17th write sets overflow; the 16 reads return 0x01..0x10 in order.
- FWFT: single write 0xA5 into empty FIFO at edge k → water_level=1 after k, rd_empty=0 and rd_data=0xA5 after k+1. rd_en pops it → rd_empty=1 next cycle.
- Simultaneous rd_en and wr_en at water_level=8 for 100 cycles → water_level stays 8, data order preserved, pointers wrap cleanly past index 15.
- rd_en on empty FIFO → underflow=1 and rd_data unchanged; underflow stays 1 until rst or flush.
- Fill to 12 with c_ALMOST_FULL_NUM=12, c_ALMOST_EMPTY_NUM=2 → almost_full=1 at level 12, 0 at level 11; almost_empty=1 at level 2, 0 at level 3.
- flush with wr_en=rd_en=1 at level 9 → next cycle water_level=0, rd_empty=1, overflow=0, and no write is accepted; rst pulsed mid-burst gives the same result asynchronously.

Source files
------------

// File: rtl/pix_buff_pkg.sv
// Shared constants and helpers for the single-clock pixel buffer FIFO.
package pix_buff_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    localparam int STAT_CNT_W     = 16;

    function automatic int fifo_capacity(input int depth_width);
        return 32'sd1 << depth_width;
    endfunction

endpackage

// File: rtl/pix_buff_sdp_ram.sv
// Inferred simple-dual-port RAM with a one-cycle registered read port.
module pix_buff_sdp_ram
    import pix_buff_pkg::*;
#(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [c_ADDR_WIDTH-1:0] wr_addr,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [c_ADDR_WIDTH-1:0] rd_addr,
    output logic [c_DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_capacity(c_ADDR_WIDTH);

    logic [c_DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output holds between reads.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/pix_buff_sync_fifo.sv
// Single-clock pixel FIFO with standard/FWFT read modes, flush, sticky flags and level.
// Optional statistics outputs are built when PIX_BUFF_FIFO_STATS_EN is defined.
module pix_buff_sync_fifo
    import pix_buff_pkg::*;
#(
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_FWFT             = 0,
    parameter int c_ALMOST_FULL_NUM  = 1020,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    output logic                     wr_full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     overflow,
`ifdef PIX_BUFF_FIFO_STATS_EN
    output logic [STAT_CNT_W-1:0]    ovf_cnt,
    output logic [STAT_CNT_W-1:0]    udf_cnt,
    output logic [c_DEPTH_WIDTH:0]   max_level,
`endif
    output logic                     underflow
);

    localparam int                     CAP      = fifo_capacity(c_DEPTH_WIDTH);
    localparam bit                     FWFT     = (c_FWFT == FIFO_MODE_FWFT);
    localparam logic [c_DEPTH_WIDTH:0] LVL_CAP  = (c_DEPTH_WIDTH+1)'(CAP);
    localparam logic [c_DEPTH_WIDTH:0] LVL_ONE  = (c_DEPTH_WIDTH+1)'(32'd1);
    localparam logic [c_DEPTH_WIDTH:0] LVL_ZERO = (c_DEPTH_WIDTH+1)'(32'd0);
    localparam logic [c_DEPTH_WIDTH-1:0] PTR_ONE = c_DEPTH_WIDTH'(32'd1);

    if (c_ALMOST_FULL_NUM > CAP) begin : g_af_range_err
        $error("pix_buff_sync_fifo: c_ALMOST_FULL_NUM exceeds capacity");
    end
    if (c_ALMOST_EMPTY_NUM >= c_ALMOST_FULL_NUM) begin : g_ae_range_err
        $error("pix_buff_sync_fifo: c_ALMOST_EMPTY_NUM must be below c_ALMOST_FULL_NUM");
    end

    logic [c_DEPTH_WIDTH-1:0] wr_ptr_r;
    logic [c_DEPTH_WIDTH-1:0] rd_ptr_r;
    logic [c_DEPTH_WIDTH:0]   level_r;
    logic [c_DEPTH_WIDTH:0]   level_nxt_s;
    logic                     full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
    logic                     wr_acc_s, rd_acc_s, ram_rd_s, ram_has_word_s;
    logic                     stage_vld_r, stage_vld_nxt_s;
    logic                     ram_vld_r;
    logic [c_DATA_WIDTH-1:0]  ram_q_s;
    logic [c_DATA_WIDTH-1:0]  rd_data_r;

    assign wr_acc_s = wr_en & ~full_r & ~flush;
    assign rd_acc_s = rd_en & ~empty_r & ~flush;

    // Next occupancy: net change of accepted writes and pops.
    always_comb begin
        level_nxt_s = level_r;
        if (flush) begin
            level_nxt_s = LVL_ZERO;
        end else if (wr_acc_s && !rd_acc_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (!wr_acc_s && rd_acc_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // In FWFT mode the head word sits in the RAM output register, so only words beyond it are fetchable.
    always_comb begin
        ram_has_word_s = 1'b0;
        if (stage_vld_r) begin
            ram_has_word_s = (level_r > LVL_ONE);
        end else begin
            ram_has_word_s = (level_r != LVL_ZERO);
        end
    end

    // RAM read issue and prefetch-stage occupancy per read mode.
    always_comb begin
        ram_rd_s        = 1'b0;
        stage_vld_nxt_s = stage_vld_r;
        if (flush) begin
            ram_rd_s        = 1'b0;
            stage_vld_nxt_s = 1'b0;
        end else if (FWFT) begin
            ram_rd_s        = ram_has_word_s & (~stage_vld_r | rd_acc_s);
            stage_vld_nxt_s = ram_rd_s | (stage_vld_r & ~rd_acc_s);
        end else begin
            ram_rd_s        = rd_acc_s;
            stage_vld_nxt_s = 1'b0;
        end
    end

    // Pointers, level, flags and read-data pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            af_r        <= 1'b0;
            ae_r        <= 1'b1;
            ovf_r       <= 1'b0;
            udf_r       <= 1'b0;
            stage_vld_r <= 1'b0;
            ram_vld_r   <= 1'b0;
            rd_data_r   <= '0;
        end else if (flush) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            af_r        <= 1'b0;
            ae_r        <= 1'b1;
            ovf_r       <= 1'b0;
            udf_r       <= 1'b0;
            stage_vld_r <= 1'b0;
            ram_vld_r   <= 1'b0;
            rd_data_r   <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (ram_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r     <= level_nxt_s;
            full_r      <= (level_nxt_s == LVL_CAP);
            empty_r     <= FWFT ? ~stage_vld_nxt_s : (level_nxt_s == LVL_ZERO);
            af_r        <= (32'(level_nxt_s) >= 32'(c_ALMOST_FULL_NUM));
            ae_r        <= (32'(level_nxt_s) <= 32'(c_ALMOST_EMPTY_NUM));
            ovf_r       <= ovf_r | (wr_en & full_r);
            udf_r       <= udf_r | (rd_en & empty_r);
            stage_vld_r <= stage_vld_nxt_s;
            // Standard mode: one-shot "RAM word pending"; FWFT: "RAM output has ever been loaded".
            ram_vld_r   <= FWFT ? (ram_vld_r | ram_rd_s) : ram_rd_s;
            if (ram_vld_r) begin
                rd_data_r <= ram_q_s;
            end
        end
    end

    pix_buff_sdp_ram #(
        .c_ADDR_WIDTH (c_DEPTH_WIDTH),
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data),
        .rd_en   (ram_rd_s),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_q_s)
    );

    assign rd_data      = FWFT ? (ram_vld_r ? ram_q_s : {c_DATA_WIDTH{1'b0}}) : rd_data_r;
    assign wr_full      = full_r;
    assign rd_empty     = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign water_level  = level_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

`ifdef PIX_BUFF_FIFO_STATS_EN
    localparam logic [STAT_CNT_W-1:0] CNT_MAX = {STAT_CNT_W{1'b1}};
    localparam logic [STAT_CNT_W-1:0] CNT_ONE = STAT_CNT_W'(32'd1);

    logic [STAT_CNT_W-1:0]  ovf_cnt_r, udf_cnt_r;
    logic [c_DEPTH_WIDTH:0] max_lvl_r;

    // Saturating drop/ignore counters and peak occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_r <= '0;
            udf_cnt_r <= '0;
            max_lvl_r <= '0;
        end else if (flush) begin
            ovf_cnt_r <= '0;
            udf_cnt_r <= '0;
            max_lvl_r <= '0;
        end else begin
            if (wr_en && full_r && (ovf_cnt_r != CNT_MAX)) begin
                ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
            end
            if (rd_en && empty_r && (udf_cnt_r != CNT_MAX)) begin
                udf_cnt_r <= udf_cnt_r + CNT_ONE;
            end
            if (level_nxt_s > max_lvl_r) begin
                max_lvl_r <= level_nxt_s;
            end
        end
    end

    assign ovf_cnt   = ovf_cnt_r;
    assign udf_cnt   = udf_cnt_r;
    assign max_level = max_lvl_r;
`endif

endmodule
